mc_sequencer: RTL and testbench
===============================

MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 CNT_W, 32, width of retired-instruction counter.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  7  IR[6:0].
REQ-005 funct3  input  3  IR[14:12].
REQ-006 funct7  input  7  IR[31:25].
REQ-007 zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  memory completes current access this cycle.
REQ-009 state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-010 pcwrite, irwrite, memread, memwrite, regwrite  output  1 each  datapath write/access strobes.
REQ-011 iord  output  1  memory address: 0 PC, 1 ALUOut.
REQ-012 alusrca  output  2  00 PC, 01 rs1, 10 zero, 11 OldPC (PC latched with IR).
REQ-013 alusrcb  output  2  00 rs2, 01 constant 4, 10 imm.
REQ-014 aluctl  output  4  0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT.
REQ-015 pcsrc  output  1  0 ALU result, 1 ALUOut.
REQ-016 wbsel  output  2  00 ALUOut, 01 memory data, 10 PC.
REQ-017 trap  output  1  illegal instruction, sticky.
REQ-018 retired  output  CNT_W  retired-instruction count.

Function
REQ-019 Outputs not listed for a state SHALL be 0; all outputs SHALL depend only on state, opcode, funct3, funct7, zero, mem_ready.
REQ-020 FETCH: iord=0, memread=1, alusrca=00, alusrcb=01, aluctl=ADD; when mem_ready=1: irwrite=1, pcwrite=1, pcsrc=0, next DECODE; else remain in FETCH with memread held.
REQ-021 DECODE: alusrca=11, alusrcb=10, aluctl=ADD (target into ALUOut); legal instruction -> EXEC; illegal -> TRAP.
REQ-022 Legal set: R 0110011 and I-ALU 0010011 with funct3 in {000,010,100,110,111} (R additionally funct7 in {0000000,0100000}, 0100000 only with 000); LOAD 0000011; STORE 0100011; BRANCH 1100011 funct3 000/001; JAL 1101111; JALR 1100111; LUI 0110111.
REQ-023 ALU op decode: funct3 000 ADD (SUB if R and funct7=0100000), 010 SLT, 100 XOR, 110 OR, 111 AND.
REQ-024 EXEC R: alusrca=01, alusrcb=00, decoded aluctl -> WB. I-ALU: same with alusrcb=10 -> WB. LUI: alusrca=10, alusrcb=10, ADD -> WB.
REQ-025 EXEC LOAD/STORE: alusrca=01, alusrcb=10, ADD -> MEM.
REQ-026 EXEC BRANCH: alusrca=01, alusrcb=00, SUB, pcsrc=1, pcwrite=zero (funct3 000) or ~zero (001) -> FETCH.
REQ-027 EXEC JAL: regwrite=1, wbsel=10, pcwrite=1, pcsrc=1 -> FETCH. JALR: alusrca=01, alusrcb=10, ADD, regwrite=1, wbsel=10, pcwrite=1, pcsrc=0 -> FETCH; register write samples pre-update PC (already PC+4).
REQ-028 MEM: iord=1; LOAD: memread=1, on mem_ready -> WB; STORE: memwrite=1, on mem_ready -> FETCH; strobe held until mem_ready.
REQ-029 WB: regwrite=1, wbsel=01 for LOAD else 00 -> FETCH.
REQ-030 retired SHALL increment by 1 on each transition into FETCH from EXEC, MEM or WB; wraps modulo 2^CNT_W.
REQ-031 TRAP: trap=1, all strobes 0, remains until reset.
REQ-032 Latency with mem_ready tied 1: R/I/LUI 4 cycles, LOAD 5, STORE 4, BRANCH/JAL/JALR 3.

Reset
REQ-033 rst=0 SHALL immediately force state=FETCH, retired=0, trap=0 and all strobes 0, abandoning any access in progress.
REQ-034 First FETCH memread=1 SHALL appear in the first cycle with rst=1.

Verification
REQ-035 mem_ready=1, ADD x3,x1,x2 -> states 0,1,2,4,0; regwrite=1 only in WB; retired 0->1.
REQ-036 LW with mem_ready low 3 cycles in MEM -> memread, iord=1 held 4 cycles, then WB with wbsel=01; total 8 cycles.
REQ-037 BEQ zero=1 -> EXEC pcwrite=1, pcsrc=1; BNE zero=1 -> pcwrite=0; both back to FETCH after 3 cycles.
REQ-038 opcode 1111111 -> DECODE then TRAP, trap=1 held 100 cycles, retired unchanged.
REQ-039 rst asserted mid-MEM of SW -> memwrite drops same cycle, state=0, retired=0; CNT_W=4 after 16 retirements -> retired=0.

Source files
------------

// File: rtl/mc_sequencer.sv
// ---------------------------------------------------------------------------
// mc_sequencer
//   Multi-cycle control sequencer for a small RV32I-style datapath.  Walks
//   each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB), drives
//   the datapath mux selects and write strobes for the current step, counts
//   retired instructions and parks in TRAP on an illegal instruction.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   opcode     IR[6:0]
//   funct3     IR[14:12]
//   funct7     IR[31:25]
//   zero       ALU zero flag (branch compare result)
//   mem_ready  memory completes the current access this cycle
//   state      current step: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
//   pcwrite, irwrite, memread, memwrite, regwrite   datapath strobes
//   iord       memory address select: 0 PC, 1 ALUOut
//   alusrca    00 PC, 01 rs1, 10 zero, 11 OldPC
//   alusrcb    00 rs2, 01 constant 4, 10 immediate
//   aluctl     0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT
//   pcsrc      0 ALU result, 1 ALUOut
//   wbsel      00 ALUOut, 01 memory data, 10 PC
//   trap       illegal instruction seen; held until reset
//   retired    retired-instruction count, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module mc_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             pcwrite,
    output logic             irwrite,
    output logic             memread,
    output logic             memwrite,
    output logic             regwrite,
    output logic             iord,
    output logic [1:0]       alusrca,
    output logic [1:0]       alusrcb,
    output logic [3:0]       aluctl,
    output logic             pcsrc,
    output logic [1:0]       wbsel,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    state_t cur_state, next_state;
    logic   retire_evt;

    logic is_r, is_ialu, is_load, is_store, is_branch, is_jal, is_jalr, is_lui;
    logic f3_alu_ok, r_f7_ok, legal;
    logic [3:0] alu_op;

    // Instruction classification and legality.  The IR stays stable for the
    // whole instruction, so MEM and WB can keep using these decodes.
    always_comb begin
        is_r      = (opcode == OP_R);
        is_ialu   = (opcode == OP_IALU);
        is_load   = (opcode == OP_LOAD);
        is_store  = (opcode == OP_STORE);
        is_branch = (opcode == OP_BRANCH);
        is_jal    = (opcode == OP_JAL);
        is_jalr   = (opcode == OP_JALR);
        is_lui    = (opcode == OP_LUI);

        case (funct3)
            3'b000, 3'b010, 3'b100, 3'b110, 3'b111: f3_alu_ok = 1'b1;
            default:                                f3_alu_ok = 1'b0;
        endcase

        // The alternate funct7 encoding only exists as SUB.
        r_f7_ok = (funct7 == F7_BASE) || ((funct7 == F7_ALT) && (funct3 == 3'b000));

        legal = (is_r && f3_alu_ok && r_f7_ok)
             || (is_ialu && f3_alu_ok)
             || is_load || is_store
             || (is_branch && (funct3[2:1] == 2'b00))
             || is_jal || is_jalr || is_lui;
    end

    // ALU operation for R and I-ALU instructions.  Only register-register
    // instructions may select SUB; I-ALU funct3=000 is always an add.
    always_comb begin
        case (funct3)
            3'b000:  alu_op = (is_r && (funct7 == F7_ALT)) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_op = ALU_SLT;
            3'b100:  alu_op = ALU_XOR;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    // Retired counter; bumps whenever an instruction finishes and hands
    // control back to FETCH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired <= '0;
        end else if (retire_evt) begin
            retired <= retired + CNT_W'(1);
        end
    end

    // Next state and datapath controls.  Everything is a pure function of the
    // state and the current inputs; while reset is asserted every output is
    // held at zero so an in-flight memory access is dropped immediately.
    always_comb begin
        next_state = cur_state;
        pcwrite    = 1'b0;
        irwrite    = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        aluctl     = 4'b0000;
        pcsrc      = 1'b0;
        wbsel      = 2'b00;
        trap       = 1'b0;

        if (rst) begin
            case (cur_state)
                FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    aluctl  = ALU_ADD;
                    if (mem_ready) begin
                        irwrite    = 1'b1;
                        pcwrite    = 1'b1;
                        next_state = DECODE;
                    end
                end
                DECODE: begin
                    // Branch/JAL target = OldPC + imm, parked in ALUOut.
                    alusrca    = 2'b11;
                    alusrcb    = 2'b10;
                    aluctl     = ALU_ADD;
                    next_state = legal ? EXEC : TRAP;
                end
                EXEC: begin
                    if (is_r) begin
                        alusrca    = 2'b01;
                        aluctl     = alu_op;
                        next_state = WB;
                    end else if (is_ialu) begin
                        alusrca    = 2'b01;
                        alusrcb    = 2'b10;
                        aluctl     = alu_op;
                        next_state = WB;
                    end else if (is_lui) begin
                        alusrca    = 2'b10;
                        alusrcb    = 2'b10;
                        aluctl     = ALU_ADD;
                        next_state = WB;
                    end else if (is_load || is_store) begin
                        alusrca    = 2'b01;
                        alusrcb    = 2'b10;
                        aluctl     = ALU_ADD;
                        next_state = MEM;
                    end else if (is_branch) begin
                        alusrca    = 2'b01;
                        aluctl     = ALU_SUB;
                        pcsrc      = 1'b1;
                        pcwrite    = funct3[0] ? ~zero : zero;
                        next_state = FETCH;
                    end else if (is_jal) begin
                        regwrite   = 1'b1;
                        wbsel      = 2'b10;
                        pcwrite    = 1'b1;
                        pcsrc      = 1'b1;
                        next_state = FETCH;
                    end else begin
                        // JALR: the link write sees the PC before this
                        // update, which already holds PC+4 from FETCH.
                        alusrca    = 2'b01;
                        alusrcb    = 2'b10;
                        aluctl     = ALU_ADD;
                        regwrite   = 1'b1;
                        wbsel      = 2'b10;
                        pcwrite    = 1'b1;
                        next_state = FETCH;
                    end
                end
                MEM: begin
                    iord = 1'b1;
                    if (is_load) begin
                        memread = 1'b1;
                        if (mem_ready) begin
                            next_state = WB;
                        end
                    end else begin
                        memwrite = 1'b1;
                        if (mem_ready) begin
                            next_state = FETCH;
                        end
                    end
                end
                WB: begin
                    regwrite   = 1'b1;
                    wbsel      = is_load ? 2'b01 : 2'b00;
                    next_state = FETCH;
                end
                TRAP: begin
                    trap = 1'b1;
                end
                default: begin
                    next_state = FETCH;
                end
            endcase
        end

        retire_evt = ((cur_state == EXEC) || (cur_state == MEM) || (cur_state == WB))
                  && (next_state == FETCH);
    end

    assign state = cur_state;

endmodule

// File: tb/tb_mc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mc_sequencer
//   Directed self-checking bench for mc_sequencer.  A 32-bit counter instance
//   carries the main checks; a CNT_W=4 instance shares the same stimulus and
//   is used to see the retired counter wrap.
// ---------------------------------------------------------------------------
module tb_mc_sequencer;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        zero;
    logic        mem_ready;

    logic [2:0]  state;
    logic        pcwrite, irwrite, memread, memwrite, regwrite, iord, pcsrc, trap;
    logic [1:0]  alusrca, alusrcb, wbsel;
    logic [3:0]  aluctl;
    logic [31:0] retired;

    logic [2:0]  state4;
    logic        pcwrite4, irwrite4, memread4, memwrite4, regwrite4, iord4, pcsrc4, trap4;
    logic [1:0]  alusrca4, alusrcb4, wbsel4;
    logic [3:0]  aluctl4;
    logic [3:0]  retired4;

    int compared   = 0;
    int mismatched = 0;
    int expRetired = 0;

    mc_sequencer #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .state(state), .pcwrite(pcwrite),
        .irwrite(irwrite), .memread(memread), .memwrite(memwrite),
        .regwrite(regwrite), .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluctl(aluctl), .pcsrc(pcsrc), .wbsel(wbsel), .trap(trap),
        .retired(retired)
    );

    mc_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .state(state4), .pcwrite(pcwrite4),
        .irwrite(irwrite4), .memread(memread4), .memwrite(memwrite4),
        .regwrite(regwrite4), .iord(iord4), .alusrca(alusrca4), .alusrcb(alusrcb4),
        .aluctl(aluctl4), .pcsrc(pcsrc4), .wbsel(wbsel4), .trap(trap4),
        .retired(retired4)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the IR fields and status inputs, then let combinational logic settle.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic z,
                                 input logic mr);
        opcode    = op;
        funct3    = f3;
        funct7    = f7;
        zero      = z;
        mem_ready = mr;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
    endtask

    // One R/I-ALU/LUI instruction with mem_ready=1: FETCH, DECODE, EXEC, WB.
    task automatic runAlu(input string tag, input logic [6:0] op,
                          input logic [2:0] f3, input logic [6:0] f7,
                          input logic [3:0] expCtl, input logic [1:0] expA,
                          input logic [1:0] expB);
        applyStimulus(op, f3, f7, 1'b0, 1'b1);
        stepCycle();
        stepCycle();
        checkOutput({tag, "_state"}, 32'(state), 32'd2);
        checkOutput({tag, "_aluctl"}, 32'(aluctl), 32'(expCtl));
        checkOutput({tag, "_alusrca"}, 32'(alusrca), 32'(expA));
        checkOutput({tag, "_alusrcb"}, 32'(alusrcb), 32'(expB));
        stepCycle();
        checkOutput({tag, "_wb"}, 32'(state), 32'd4);
        stepCycle();
        expRetired++;
        checkOutput({tag, "_retired"}, retired, 32'(expRetired));
    endtask

    initial begin
        int holdCnt;
        int trapCnt;

        rst = 1'b0;
        applyStimulus(OP_R, 3'b000, 7'b0000000, 1'b0, 1'b1);
        #2;

        // Reset state: everything quiet even though state is FETCH.
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_memread", 32'(memread), 32'd0);
        checkOutput("rst_retired", retired, 32'd0);
        checkOutput("rst_trap", 32'(trap), 32'd0);

        // ADD x3,x1,x2: memread appears in the first cycle out of reset.
        releaseReset();
        checkOutput("add_f_state", 32'(state), 32'd0);
        checkOutput("add_f_memread", 32'(memread), 32'd1);
        checkOutput("add_f_irwrite", 32'(irwrite), 32'd1);
        checkOutput("add_f_pcwrite", 32'(pcwrite), 32'd1);
        checkOutput("add_f_alusrcb", 32'(alusrcb), 32'd1);
        checkOutput("add_f_aluctl", 32'(aluctl), 32'd2);
        stepCycle();
        checkOutput("add_d_state", 32'(state), 32'd1);
        checkOutput("add_d_alusrca", 32'(alusrca), 32'd3);
        checkOutput("add_d_alusrcb", 32'(alusrcb), 32'd2);
        checkOutput("add_d_regwrite", 32'(regwrite), 32'd0);
        stepCycle();
        checkOutput("add_e_state", 32'(state), 32'd2);
        checkOutput("add_e_alusrca", 32'(alusrca), 32'd1);
        checkOutput("add_e_alusrcb", 32'(alusrcb), 32'd0);
        checkOutput("add_e_aluctl", 32'(aluctl), 32'd2);
        checkOutput("add_e_regwrite", 32'(regwrite), 32'd0);
        stepCycle();
        checkOutput("add_w_state", 32'(state), 32'd4);
        checkOutput("add_w_regwrite", 32'(regwrite), 32'd1);
        checkOutput("add_w_wbsel", 32'(wbsel), 32'd0);
        checkOutput("add_w_retired", retired, 32'd0);
        stepCycle();
        expRetired = 1;
        checkOutput("add_done_state", 32'(state), 32'd0);
        checkOutput("add_done_retired", retired, 32'd1);

        // ALU decode variants.
        runAlu("sub",  OP_R,    3'b000, 7'b0100000, 4'b0110, 2'b01, 2'b00);
        runAlu("slt",  OP_R,    3'b010, 7'b0000000, 4'b0111, 2'b01, 2'b00);
        runAlu("xori", OP_IALU, 3'b100, 7'b0000000, 4'b0011, 2'b01, 2'b10);
        runAlu("ori",  OP_IALU, 3'b110, 7'b0000000, 4'b0001, 2'b01, 2'b10);
        runAlu("and",  OP_R,    3'b111, 7'b0000000, 4'b0000, 2'b01, 2'b00);
        runAlu("addi", OP_IALU, 3'b000, 7'b0100000, 4'b0010, 2'b01, 2'b10);
        runAlu("lui",  OP_LUI,  3'b011, 7'b1010101, 4'b0010, 2'b10, 2'b10);

        // LW with fetch stall, then memory held off for 3 cycles in MEM.
        applyStimulus(OP_LOAD, 3'b010, 7'b0000000, 1'b0, 1'b0);
        checkOutput("fstall_memread", 32'(memread), 32'd1);
        checkOutput("fstall_irwrite", 32'(irwrite), 32'd0);
        stepCycle();
        checkOutput("fstall_state", 32'(state), 32'd0);
        applyStimulus(OP_LOAD, 3'b010, 7'b0000000, 1'b0, 1'b1);
        stepCycle();
        stepCycle();
        checkOutput("lw_e_alusrcb", 32'(alusrcb), 32'd2);
        applyStimulus(OP_LOAD, 3'b010, 7'b0000000, 1'b0, 1'b0);
        stepCycle();
        holdCnt = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_LOAD, 3'b010, 7'b0000000, 1'b0, (i == 3));
            if (state == 3'd3 && memread && iord) holdCnt++;
            if (i < 3) stepCycle();
        end
        checkOutput("lw_hold", 32'(holdCnt), 32'd4);
        stepCycle();
        checkOutput("lw_w_state", 32'(state), 32'd4);
        checkOutput("lw_w_wbsel", 32'(wbsel), 32'd1);
        checkOutput("lw_w_regwrite", 32'(regwrite), 32'd1);
        stepCycle();
        expRetired++;
        checkOutput("lw_retired", retired, 32'(expRetired));

        // BEQ / BNE with zero=1.
        applyStimulus(OP_BRANCH, 3'b000, 7'b0000000, 1'b1, 1'b1);
        stepCycle();
        stepCycle();
        checkOutput("beq_pcwrite", 32'(pcwrite), 32'd1);
        checkOutput("beq_pcsrc", 32'(pcsrc), 32'd1);
        checkOutput("beq_aluctl", 32'(aluctl), 32'd6);
        stepCycle();
        checkOutput("beq_state", 32'(state), 32'd0);
        expRetired++;
        applyStimulus(OP_BRANCH, 3'b001, 7'b0000000, 1'b1, 1'b1);
        stepCycle();
        stepCycle();
        checkOutput("bne_pcwrite", 32'(pcwrite), 32'd0);
        checkOutput("bne_pcsrc", 32'(pcsrc), 32'd1);
        stepCycle();
        checkOutput("bne_state", 32'(state), 32'd0);
        expRetired++;
        checkOutput("br_retired", retired, 32'(expRetired));

        // JAL and JALR.
        applyStimulus(OP_JAL, 3'b000, 7'b0000000, 1'b0, 1'b1);
        stepCycle();
        stepCycle();
        checkOutput("jal_regwrite", 32'(regwrite), 32'd1);
        checkOutput("jal_wbsel", 32'(wbsel), 32'd2);
        checkOutput("jal_pcwrite", 32'(pcwrite), 32'd1);
        checkOutput("jal_pcsrc", 32'(pcsrc), 32'd1);
        stepCycle();
        expRetired++;
        applyStimulus(OP_JALR, 3'b000, 7'b0000000, 1'b0, 1'b1);
        stepCycle();
        stepCycle();
        checkOutput("jalr_pcsrc", 32'(pcsrc), 32'd0);
        checkOutput("jalr_alusrcb", 32'(alusrcb), 32'd2);
        checkOutput("jalr_wbsel", 32'(wbsel), 32'd2);
        stepCycle();
        expRetired++;
        checkOutput("jalr_retired", retired, 32'(expRetired));

        // Illegal R encoding: alternate funct7 is only valid with funct3=000.
        applyStimulus(OP_R, 3'b010, 7'b0100000, 1'b0, 1'b1);
        stepCycle();
        stepCycle();
        checkOutput("illr_state", 32'(state), 32'd5);
        checkOutput("illr_trap", 32'(trap), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("illr_rst_trap", 32'(trap), 32'd0);
        expRetired = 0;

        // Opcode 1111111: DECODE then TRAP, sticky for 100 cycles.
        applyStimulus(7'b1111111, 3'b000, 7'b0000000, 1'b0, 1'b1);
        releaseReset();
        stepCycle();
        checkOutput("ill_d_state", 32'(state), 32'd1);
        stepCycle();
        trapCnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (state == 3'd5 && trap && !memread && !memwrite && !regwrite
                && !pcwrite && !irwrite) trapCnt++;
            stepCycle();
        end
        checkOutput("ill_trap_hold", 32'(trapCnt), 32'd100);
        checkOutput("ill_retired", retired, 32'd0);

        // SW with memory stalled; reset mid-MEM drops memwrite at once.
        rst = 1'b0;
        #1;
        applyStimulus(OP_STORE, 3'b010, 7'b0000000, 1'b0, 1'b1);
        releaseReset();
        stepCycle();
        stepCycle();
        applyStimulus(OP_STORE, 3'b010, 7'b0000000, 1'b0, 1'b0);
        stepCycle();
        checkOutput("sw_m_state", 32'(state), 32'd3);
        checkOutput("sw_m_memwrite", 32'(memwrite), 32'd1);
        checkOutput("sw_m_iord", 32'(iord), 32'd1);
        stepCycle();
        checkOutput("sw_m_held", 32'(memwrite), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("sw_rst_memwrite", 32'(memwrite), 32'd0);
        checkOutput("sw_rst_state", 32'(state), 32'd0);
        checkOutput("sw_rst_retired", retired, 32'd0);

        // 16 JALs: the 4-bit counter wraps back to 0.
        applyStimulus(OP_JAL, 3'b000, 7'b0000000, 1'b0, 1'b1);
        releaseReset();
        for (int i = 0; i < 16; i++) begin
            stepCycle();
            stepCycle();
            stepCycle();
            if (i == 14) checkOutput("wrap_15", 32'(retired4), 32'd15);
        end
        checkOutput("wrap_16", 32'(retired4), 32'd0);
        checkOutput("count_16", retired, 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
